// File: rtl/cpu_core_p.sv
// cpu_core_p: parametrised single-cycle CPU core with ALU ops, branches,
// an instruction-valid stall input and a retired-instruction counter.
`default_nettype none

module cpu_core_p #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_COUNT  = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        INSTR_VALID,
  output logic [31:0] PC,
  output logic        RETIRED,
  output logic [31:0] INSTR_COUNT
);

  localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  localparam logic [7:0] c_OP_LOADI = 8'h00;
  localparam logic [7:0] c_OP_MOV   = 8'h01;
  localparam logic [7:0] c_OP_ADD   = 8'h02;
  localparam logic [7:0] c_OP_SUB   = 8'h03;
  localparam logic [7:0] c_OP_AND   = 8'h04;
  localparam logic [7:0] c_OP_OR    = 8'h05;
  localparam logic [7:0] c_OP_J     = 8'h06;
  localparam logic [7:0] c_OP_BEQ   = 8'h07;
  localparam logic [7:0] c_OP_BNE   = 8'h08;

  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
  logic [31:0]           r_pc;
  logic [31:0]           r_count;
  logic                  r_retired;

  logic [7:0]            w_op;
  logic [IDX_W-1:0]      w_dst;
  logic [IDX_W-1:0]      w_src1;
  logic [IDX_W-1:0]      w_src2;
  logic [DATA_WIDTH-1:0] w_imm;
  logic [31:0]           w_offset;
  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;
  logic [DATA_WIDTH-1:0] w_diff;
  logic                  w_zero;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_we;
  logic                  w_take;
  logic [31:0]           w_pc_seq;
  logic [31:0]           w_next_pc;
  logic                  w_commit;
  logic                  w_unused;

  assign w_op     = INSTRUCTION[31:24];
  assign w_dst    = INSTRUCTION[16 +: IDX_W];
  assign w_src1   = INSTRUCTION[8 +: IDX_W];
  assign w_src2   = INSTRUCTION[0 +: IDX_W];
  assign w_imm    = DATA_WIDTH'($signed(INSTRUCTION[7:0]));
  assign w_offset = {{22{INSTRUCTION[23]}}, INSTRUCTION[23:16], 2'b00};
  // Upper index bits are deliberately ignored; fold them here so nothing dangles.
  assign w_unused = ^INSTRUCTION;

  assign w_a    = r_regs[w_src1];
  assign w_b    = r_regs[w_src2];
  assign w_diff = w_a + (~w_b + 1'b1);
  assign w_zero = (w_diff == '0);

  always_comb begin
    w_we     = 1'b0;
    w_result = '0;
    w_take   = 1'b0;
    case (w_op)
      c_OP_LOADI: begin w_we = 1'b1; w_result = w_imm;     end
      c_OP_MOV:   begin w_we = 1'b1; w_result = w_b;       end
      c_OP_ADD:   begin w_we = 1'b1; w_result = w_a + w_b; end
      c_OP_SUB:   begin w_we = 1'b1; w_result = w_diff;    end
      c_OP_AND:   begin w_we = 1'b1; w_result = w_a & w_b; end
      c_OP_OR:    begin w_we = 1'b1; w_result = w_a | w_b; end
      c_OP_J:     w_take = 1'b1;
      c_OP_BEQ:   w_take = w_zero;
      c_OP_BNE:   w_take = ~w_zero;
      default:    ;
    endcase
  end

  assign w_pc_seq  = r_pc + 32'd4;
  assign w_next_pc = w_take ? (w_pc_seq + w_offset) : w_pc_seq;
  assign w_commit  = RESET && INSTR_VALID;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit && w_we) begin
      r_regs[w_dst] <= w_result;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_pc      <= 32'd0;
      r_count   <= 32'd0;
      r_retired <= 1'b0;
    end else if (INSTR_VALID) begin
      r_pc      <= w_next_pc;
      r_count   <= r_count + 32'd1;
      r_retired <= 1'b1;
    end else begin
      r_retired <= 1'b0;
    end
  end

  assign PC          = r_pc;
  assign RETIRED     = r_retired;
  assign INSTR_COUNT = r_count;

endmodule

`default_nettype wire

// File: tb/tb_cpu_core_p.sv
// Self-checking bench for cpu_core_p: vector table, directed corner cases
// and randomized programs compared against an arithmetic reference model.
`default_nettype none

module tb_cpu_core_p;

  localparam int          DW    = 16;
  localparam int          RC    = 8;
  localparam logic [31:0] DMASK = 32'h0000_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        ret;
  logic [31:0] cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [RC];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_ret;

  typedef struct {
    logic [31:0] ins;
    logic        valid;
    logic        rstn;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic        exp_ret;
    int          ridx;
    logic [31:0] exp_reg;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  cpu_core_p #(.DATA_WIDTH(DW), .REG_COUNT(RC)) dut (
    .CLK         (clk),
    .RESET       (rst_n),
    .INSTRUCTION (instr),
    .INSTR_VALID (vld),
    .PC          (pc),
    .RETIRED     (ret),
    .INSTR_COUNT (cnt)
  );

  function automatic logic [31:0] enc(input logic [7:0] op, input logic [7:0] d,
                                      input logic [7:0] s1, input logic [7:0] s2);
    return {op, d, s1, s2};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reg(input string name, input int idx, input logic [31:0] exp);
    logic [31:0] v;
    v = {16'b0, dut.r_regs[idx]};
    check(name, v, exp);
  endtask

  // Reference behaviour: one architectural step per call, in plain arithmetic.
  task automatic model_apply(input logic [31:0] ins, input logic v, input logic rn);
    logic [7:0]        op;
    int                d, s1, s2;
    logic [31:0]       a, b;
    logic signed [7:0] sb;
    logic signed [7:0] off;
    logic              take;
    if (!rn) begin
      for (int i = 0; i < RC; i++) m_regs[i] = 32'd0;
      m_pc  = 32'd0;
      m_cnt = 32'd0;
      m_ret = 1'b0;
    end else if (v) begin
      op   = ins[31:24];
      d    = int'(ins[23:16]) % RC;
      s1   = int'(ins[15:8]) % RC;
      s2   = int'(ins[7:0]) % RC;
      sb   = ins[7:0];
      off  = ins[23:16];
      a    = m_regs[s1];
      b    = m_regs[s2];
      take = 1'b0;
      case (op)
        8'h00: m_regs[d] = 32'(int'(sb)) & DMASK;
        8'h01: m_regs[d] = b;
        8'h02: m_regs[d] = (a + b) & DMASK;
        8'h03: m_regs[d] = (a - b) & DMASK;
        8'h04: m_regs[d] = a & b;
        8'h05: m_regs[d] = a | b;
        8'h06: take = 1'b1;
        8'h07: take = (a == b);
        8'h08: take = (a != b);
        default: ;
      endcase
      m_pc  = take ? (m_pc + 32'd4 + 32'(int'(off) * 4)) : (m_pc + 32'd4);
      m_cnt = m_cnt + 32'd1;
      m_ret = 1'b1;
    end else begin
      m_ret = 1'b0;
    end
  endtask

  task automatic step(input logic [31:0] ins, input logic v, input logic rn);
    instr = ins;
    vld   = v;
    rst_n = rn;
    model_apply(ins, v, rn);
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("count", cnt, m_cnt);
    check("retired", {31'b0, ret}, {31'b0, m_ret});
    for (int i = 0; i < RC; i++) check_reg($sformatf("r%0d", i), i, m_regs[i]);
  endtask

  initial begin
    instr = 32'd0;
    vld   = 1'b0;
    rst_n = 1'b0;

    tbl[0] = '{enc(8'h00, 8'd0, 8'd0, 8'd0), 1'b1, 1'b0, 32'd0,  32'd0, 1'b0, 1, 32'd0};
    tbl[1] = '{enc(8'h00, 8'd0, 8'd0, 8'd0), 1'b1, 1'b0, 32'd0,  32'd0, 1'b0, 3, 32'd0};
    tbl[2] = '{enc(8'h00, 8'd1, 8'd0, 8'd5), 1'b1, 1'b1, 32'd4,  32'd1, 1'b1, 1, 32'd5};
    tbl[3] = '{enc(8'h00, 8'd2, 8'd0, 8'd3), 1'b1, 1'b1, 32'd8,  32'd2, 1'b1, 2, 32'd3};
    tbl[4] = '{enc(8'h02, 8'd3, 8'd1, 8'd2), 1'b1, 1'b1, 32'd12, 32'd3, 1'b1, 3, 32'd8};
    tbl[5] = '{enc(8'h03, 8'd4, 8'd1, 8'd2), 1'b1, 1'b1, 32'd16, 32'd4, 1'b1, 4, 32'd2};
    tbl[6] = '{enc(8'h04, 8'd5, 8'd1, 8'd2), 1'b1, 1'b1, 32'd20, 32'd5, 1'b1, 5, 32'd1};
    tbl[7] = '{enc(8'h05, 8'd6, 8'd1, 8'd2), 1'b1, 1'b1, 32'd24, 32'd6, 1'b1, 6, 32'd7};

    #2;
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].ins, tbl[i].valid, tbl[i].rstn);
      check($sformatf("vec%0d_pc", i), pc, tbl[i].exp_pc);
      check($sformatf("vec%0d_count", i), cnt, tbl[i].exp_cnt);
      check($sformatf("vec%0d_retired", i), {31'b0, ret}, {31'b0, tbl[i].exp_ret});
      check_reg($sformatf("vec%0d_reg", i), tbl[i].ridx, tbl[i].exp_reg);
    end

    // Sign extension and 16-bit wrap.
    step(enc(8'h00, 8'd1, 8'd0, 8'hFF), 1'b1, 1'b1);
    step(enc(8'h00, 8'd2, 8'd0, 8'd1), 1'b1, 1'b1);
    step(enc(8'h02, 8'd3, 8'd1, 8'd2), 1'b1, 1'b1);
    step(enc(8'h03, 8'd4, 8'd2, 8'd1), 1'b1, 1'b1);
    check_reg("wrap_r1", 1, 32'h0000_FFFF);
    check_reg("wrap_r3", 3, 32'h0000_0000);
    check_reg("wrap_r4", 4, 32'h0000_0002);

    // Branches from a fresh reset.
    step(32'd0, 1'b1, 1'b0);
    step(enc(8'h07, 8'd2, 8'd1, 8'd1), 1'b1, 1'b1);
    check("beq_taken_pc", pc, 32'd12);
    step(enc(8'h06, 8'hFD, 8'd0, 8'd0), 1'b1, 1'b1);
    check("j_back_pc", pc, 32'd4);
    step(enc(8'h08, 8'd5, 8'd1, 8'd1), 1'b1, 1'b1);
    check("bne_not_taken_pc", pc, 32'd8);

    // Stall for three cycles, then resume.
    step(enc(8'h00, 8'd2, 8'd0, 8'd7), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(enc(8'h00, 8'd2, 8'd0, 8'd99), 1'b0, 1'b1);
      check("stall_pc", pc, 32'd12);
      check("stall_count", cnt, 32'd4);
      check("stall_retired", {31'b0, ret}, 32'd0);
      check_reg("stall_r2", 2, 32'd7);
    end
    step(enc(8'h02, 8'd3, 8'd2, 8'd2), 1'b1, 1'b1);
    check("resume_r3", {16'b0, dut.r_regs[3]}, 32'd14);
    check("resume_pc", pc, 32'd16);
    check("resume_retired", {31'b0, ret}, 32'd1);

    // Reset arriving with an instruction in flight.
    step(enc(8'h00, 8'd7, 8'd0, 8'd3), 1'b1, 1'b1);
    step(enc(8'h00, 8'd7, 8'd0, 8'd9), 1'b1, 1'b0);
    check_reg("midrst_r7", 7, 32'd0);
    check("midrst_pc", pc, 32'd0);
    check("midrst_count", cnt, 32'd0);
    check("midrst_retired", {31'b0, ret}, 32'd0);

    // Unknown opcode and destination index masking.
    step(enc(8'hAA, 8'd1, 8'd2, 8'd3), 1'b1, 1'b1);
    check("unk_pc", pc, 32'd4);
    check("unk_count", cnt, 32'd1);
    check_reg("unk_r1", 1, 32'd0);
    step(enc(8'h00, 8'h09, 8'd0, 8'h42), 1'b1, 1'b1);
    check_reg("mask_r1", 1, 32'h42);

    // Randomized programs against the model.
    for (int n = 0; n < 600; n++) begin
      logic [7:0]  op;
      logic [31:0] ins;
      int          sel;
      sel = int'($urandom_range(0, 11));
      if (sel <= 8)       op = 8'(sel);
      else if (sel == 9)  op = 8'h00;
      else                op = 8'($urandom_range(9, 255));
      ins = {op, 8'($urandom), 8'($urandom_range(0, 15)), 8'($urandom)};
      if (op == 8'h00) ins[7:0] = 8'($urandom_range(0, 3));
      step(ins, ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
